// File: rtl/lock_controller.sv
// Keypad door lock sequencer: owns the stored PIN, collects digit entry,
// and runs the locked / unlocked / PIN-change / lockout state machine.
// Every output comes straight from a register.
module lock_controller #(
  parameter logic [15:0] INIT_PIN    = 16'h4321,
  parameter int          MAX_FAIL    = 3,
  parameter int          UNLOCK_SEC  = 5,
  parameter int          LOCKOUT_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        change_req,
  output logic [15:0] entry,
  output logic [2:0]  entry_count,
  output logic [2:0]  status,
  output logic [1:0]  fail_count,
  output logic [3:0]  timer
);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_UNLOCKED = 3'd1,
    S_NEW_PIN  = 3'd2,
    S_CONFIRM  = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  localparam logic [3:0] LP_UNLOCK_T  = 4'(UNLOCK_SEC);
  localparam logic [3:0] LP_LOCKOUT_T = 4'(LOCKOUT_SEC);
  localparam logic [2:0] LP_MAX_FAIL  = 3'(MAX_FAIL);

  state_t      r_state;
  logic [15:0] r_entry;
  logic [2:0]  r_count;
  logic [1:0]  r_fail;
  logic [3:0]  r_timer;
  logic [15:0] r_pin;
  logic [15:0] r_cand;

  state_t      w_state_nxt;
  logic [15:0] w_entry_nxt;
  logic [2:0]  w_count_nxt;
  logic [1:0]  w_fail_nxt;
  logic [3:0]  w_timer_nxt;
  logic [15:0] w_pin_nxt;
  logic [15:0] w_cand_nxt;

  logic        w_is_digit;
  logic        w_is_clear;
  logic        w_is_enter;
  logic        w_any_key;
  logic        w_full;
  logic [15:0] w_entry_app;
  logic [15:0] w_edit_entry;
  logic [2:0]  w_edit_count;
  logic        w_pin_match;
  logic        w_cand_match;
  logic [2:0]  w_fail_inc;
  logic [3:0]  w_timer_dec;
  logic        w_expire;

  // Key decode; codes A-D fall through every class and so do nothing.
  assign w_is_digit = key_valid && (key_code <= 4'd9);
  assign w_is_clear = key_valid && (key_code == 4'hE);
  assign w_is_enter = key_valid && (key_code == 4'hF);
  assign w_any_key  = w_is_digit || w_is_clear || w_is_enter;

  // Buffer edit for digit/clear: new digit lands in the next free nibble,
  // a fifth digit is dropped.
  assign w_full       = (r_count == 3'd4);
  assign w_entry_app  = r_entry | ({12'h000, key_code} << {r_count[1:0], 2'b00});
  assign w_edit_entry = w_is_clear ? 16'h0000 :
                        ((w_is_digit && !w_full) ? w_entry_app : r_entry);
  assign w_edit_count = w_is_clear ? 3'd0 :
                        ((w_is_digit && !w_full) ? (r_count + 3'd1) : r_count);

  assign w_pin_match  = w_full && (r_entry == r_pin);
  assign w_cand_match = w_full && (r_entry == r_cand);
  assign w_fail_inc   = {1'b0, r_fail} + 3'd1;

  // Timer never underflows; a tick seen at 1 is the expiry.
  assign w_timer_dec  = (r_timer == 4'd0) ? 4'd0 : (r_timer - 4'd1);
  assign w_expire     = (r_timer == 4'd1);

  // Next-state and next-register computation; key actions beat ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_entry_nxt = r_entry;
    w_count_nxt = r_count;
    w_fail_nxt  = r_fail;
    w_timer_nxt = r_timer;
    w_pin_nxt   = r_pin;
    w_cand_nxt  = r_cand;
    case (r_state)
      S_LOCKED: begin
        if (w_is_enter) begin
          w_entry_nxt = 16'h0000;
          w_count_nxt = 3'd0;
          if (w_pin_match) begin
            w_state_nxt = S_UNLOCKED;
            w_fail_nxt  = 2'd0;
            w_timer_nxt = LP_UNLOCK_T;
          end else if (w_fail_inc == LP_MAX_FAIL) begin
            w_state_nxt = S_LOCKOUT;
            w_fail_nxt  = 2'd0;
            w_timer_nxt = LP_LOCKOUT_T;
          end else begin
            w_fail_nxt  = w_fail_inc[1:0];
          end
        end else begin
          w_entry_nxt = w_edit_entry;
          w_count_nxt = w_edit_count;
        end
      end
      S_UNLOCKED: begin
        if (w_is_enter) begin
          if (change_req) begin
            w_state_nxt = S_NEW_PIN;
            w_timer_nxt = LP_UNLOCK_T;
          end else begin
            w_state_nxt = S_LOCKED;
            w_timer_nxt = 4'd0;
          end
        end else if (tick_1hz) begin
          if (w_expire) begin
            w_state_nxt = S_LOCKED;
            w_timer_nxt = 4'd0;
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      S_NEW_PIN, S_CONFIRM: begin
        if (!change_req) begin
          w_state_nxt = S_LOCKED;
          w_timer_nxt = 4'd0;
          w_entry_nxt = 16'h0000;
          w_count_nxt = 3'd0;
        end else if (w_any_key) begin
          w_timer_nxt = LP_UNLOCK_T;
          if (w_is_enter) begin
            w_entry_nxt = 16'h0000;
            w_count_nxt = 3'd0;
            if (r_state == S_NEW_PIN) begin
              if (w_full) begin
                w_cand_nxt  = r_entry;
                w_state_nxt = S_CONFIRM;
              end else begin
                w_state_nxt = S_NEW_PIN;
              end
            end else if (w_cand_match) begin
              w_pin_nxt   = r_cand;
              w_state_nxt = S_LOCKED;
              w_timer_nxt = 4'd0;
            end else begin
              w_state_nxt = S_NEW_PIN;
            end
          end else begin
            w_entry_nxt = w_edit_entry;
            w_count_nxt = w_edit_count;
          end
        end else if (tick_1hz) begin
          if (w_expire) begin
            w_state_nxt = S_LOCKED;
            w_timer_nxt = 4'd0;
            w_entry_nxt = 16'h0000;
            w_count_nxt = 3'd0;
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      S_LOCKOUT: begin
        w_entry_nxt = 16'h0000;
        w_count_nxt = 3'd0;
        if (tick_1hz) begin
          if (w_expire) begin
            w_state_nxt = S_LOCKED;
            w_timer_nxt = 4'd0;
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      default: begin
        w_state_nxt = S_LOCKED;
        w_entry_nxt = 16'h0000;
        w_count_nxt = 3'd0;
        w_fail_nxt  = 2'd0;
        w_timer_nxt = 4'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOCKED;
      r_entry <= 16'h0000;
      r_count <= 3'd0;
      r_fail  <= 2'd0;
      r_timer <= 4'd0;
      r_pin   <= INIT_PIN;
      r_cand  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_entry <= w_entry_nxt;
      r_count <= w_count_nxt;
      r_fail  <= w_fail_nxt;
      r_timer <= w_timer_nxt;
      r_pin   <= w_pin_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  assign entry       = r_entry;
  assign entry_count = r_count;
  assign status      = r_state;
  assign fail_count  = r_fail;
  assign timer       = r_timer;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: a queue-based behavioural model checked every
// cycle, plus hand-computed literal checkpoints from the lock's rules.
module tb_lock_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        change_req;
  logic [15:0] entry;
  logic [2:0]  entry_count;
  logic [2:0]  status;
  logic [1:0]  fail_count;
  logic [3:0]  timer;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_st;
  logic [15:0] m_pin;
  logic [15:0] m_cand;
  int          dq[$];
  int          m_fail;
  int          m_timer;

  lock_controller dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_code(key_code), .change_req(change_req), .entry(entry),
    .entry_count(entry_count), .status(status), .fail_count(fail_count),
    .timer(timer)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] entry_val();
    logic [15:0] v;
    v = 16'h0000;
    foreach (dq[i]) v = v | (16'(dq[i]) << (4 * i));
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pin = 16'h4321; m_cand = 16'h0000;
    dq.delete(); m_fail = 0; m_timer = 0;
  endtask

  // One clock of lock behaviour, from the rules, for the currently driven inputs.
  task automatic model_step();
    bit dig, clr, ent, anyk;
    dig  = key_valid && (key_code <= 4'd9);
    clr  = key_valid && (key_code == 4'hE);
    ent  = key_valid && (key_code == 4'hF);
    anyk = dig || clr || ent;
    if (m_st == 0) begin
      if (ent) begin
        if (dq.size() == 4 && entry_val() == m_pin) begin
          m_st = 1; m_fail = 0; m_timer = 5;
        end else begin
          m_fail = m_fail + 1;
          if (m_fail == 3) begin m_st = 4; m_timer = 10; m_fail = 0; end
        end
        dq.delete();
      end else if (dig) begin
        if (dq.size() < 4) dq.push_back(int'(key_code));
      end else if (clr) dq.delete();
    end else if (m_st == 1) begin
      if (ent) begin
        if (change_req) begin m_st = 2; m_timer = 5; end
        else begin m_st = 0; m_timer = 0; end
      end else if (tick_1hz && m_timer > 0) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) m_st = 0;
      end
    end else if (m_st == 2 || m_st == 3) begin
      if (!change_req) begin
        m_st = 0; m_timer = 0; dq.delete();
      end else if (anyk) begin
        m_timer = 5;
        if (dig && dq.size() < 4) dq.push_back(int'(key_code));
        if (clr) dq.delete();
        if (ent) begin
          if (m_st == 2) begin
            if (dq.size() == 4) begin m_cand = entry_val(); m_st = 3; end
          end else begin
            if (dq.size() == 4 && entry_val() == m_cand) begin
              m_pin = m_cand; m_st = 0; m_timer = 0;
            end else m_st = 2;
          end
          dq.delete();
        end
      end else if (tick_1hz && m_timer > 0) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin m_st = 0; dq.delete(); end
      end
    end else begin
      if (tick_1hz && m_timer > 0) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) m_st = 0;
      end
    end
  endtask

  task automatic checkv(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkv("m_status", 16'(status), 16'(m_st));
      checkv("m_entry", entry, entry_val());
      checkv("m_count", 16'(entry_count), 16'(dq.size()));
      checkv("m_fail", 16'(fail_count), 16'(m_fail));
      checkv("m_timer", 16'(timer), 16'(m_timer));
    end
  end

  task automatic cyc(input logic kv, input logic [3:0] kc, input logic tk);
    @(negedge clk); #1;
    key_valid = kv; key_code = kc; tick_1hz = tk;
    model_step();
  endtask

  task automatic key(input logic [3:0] kc);
    cyc(1'b1, kc, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b1);
  endtask

  task automatic try4(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d); key(4'hF);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0; key_code = 4'h0; change_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1; rst = 1'b0; model_step(); chk_en = 1'b1;
    settle();
    checkv("reset_status", 16'(status), 16'd0);
    checkv("reset_timer", 16'(timer), 16'd0);

    // 1: unlock with initial PIN, auto-relock after 5 ticks
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); settle();
    checkv("t1_entry", entry, 16'h4321);
    checkv("t1_count", 16'(entry_count), 16'd4);
    key(4'hF); settle();
    checkv("t1_unlock", 16'(status), 16'd1);
    checkv("t1_timer5", 16'(timer), 16'd5);
    checkv("t1_entry0", entry, 16'h0000);
    ticks(4); settle();
    checkv("t1_timer1", 16'(timer), 16'd1);
    ticks(1); settle();
    checkv("t1_relock", 16'(status), 16'd0);
    ticks(1); settle();
    checkv("t1_lockedtick", 16'(timer), 16'd0);

    // 2: three failures -> lockout, keys ignored, 10 ticks
    try4(4'd9, 4'd9, 4'd9, 4'd9); settle();
    checkv("t2_fail1", 16'(fail_count), 16'd1);
    try4(4'd9, 4'd9, 4'd9, 4'd9); settle();
    checkv("t2_fail2", 16'(fail_count), 16'd2);
    try4(4'd9, 4'd9, 4'd9, 4'd9); settle();
    checkv("t2_lockout", 16'(status), 16'd4);
    checkv("t2_timer10", 16'(timer), 16'd10);
    checkv("t2_fail0", 16'(fail_count), 16'd0);
    try4(4'd1, 4'd2, 4'd3, 4'd4); settle();
    checkv("t2_ignored", 16'(status), 16'd4);
    checkv("t2_ign_timer", 16'(timer), 16'd10);
    ticks(9); settle();
    checkv("t2_timer1", 16'(timer), 16'd1);
    ticks(1); settle();
    checkv("t2_release", 16'(status), 16'd0);

    // 3: PIN change to 5678
    try4(4'd1, 4'd2, 4'd3, 4'd4);
    change_req = 1'b1;
    key(4'hF); settle();
    checkv("t3_newpin", 16'(status), 16'd2);
    try4(4'd5, 4'd6, 4'd7, 4'd8); settle();
    checkv("t3_confirm", 16'(status), 16'd3);
    try4(4'd5, 4'd6, 4'd7, 4'd8); settle();
    checkv("t3_stored", 16'(status), 16'd0);
    try4(4'd1, 4'd2, 4'd3, 4'd4); settle();
    checkv("t3_oldfails", 16'(fail_count), 16'd1);
    try4(4'd5, 4'd6, 4'd7, 4'd8); settle();
    checkv("t3_newunlock", 16'(status), 16'd1);

    // 4: confirm mismatch, key+tick reload, abort, old PIN kept
    key(4'hF);
    try4(4'd2, 4'd4, 4'd6, 4'd8);
    try4(4'd2, 4'd4, 4'd6, 4'd9); settle();
    checkv("t4_backnew", 16'(status), 16'd2);
    ticks(2); settle();
    checkv("t4_timer3", 16'(timer), 16'd3);
    cyc(1'b1, 4'd1, 1'b1); settle();
    checkv("t4_reload", 16'(timer), 16'd5);
    checkv("t4_entry1", entry, 16'h0001);
    change_req = 1'b0;
    cyc(1'b1, 4'd2, 1'b0); settle();
    checkv("t4_abort", 16'(status), 16'd0);
    checkv("t4_abort_buf", 16'(entry_count), 16'd0);
    try4(4'd2, 4'd4, 4'd6, 4'd8); settle();
    checkv("t4_nochange", 16'(fail_count), 16'd1);
    try4(4'd5, 4'd6, 4'd7, 4'd8); settle();
    checkv("t4_oldpin", 16'(status), 16'd1);

    // 5: short entry, fifth digit, key/tick collision, NEW_PIN expiry
    key(4'hF);
    key(4'd5); key(4'd6); key(4'hE); key(4'd7); key(4'd8); key(4'hF); settle();
    checkv("t5_short", 16'(fail_count), 16'd1);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8); key(4'd9); settle();
    checkv("t5_entry", entry, 16'h8765);
    checkv("t5_count4", 16'(entry_count), 16'd4);
    key(4'hE);
    try4(4'd5, 4'd6, 4'd7, 4'd8);
    cyc(1'b1, 4'hA, 1'b1); settle();
    checkv("t5_ignkey_tick", 16'(timer), 16'd4);
    cyc(1'b1, 4'hF, 1'b1); settle();
    checkv("t5_enter_tick", 16'(status), 16'd0);
    checkv("t5_enter_tmr", 16'(timer), 16'd0);
    try4(4'd5, 4'd6, 4'd7, 4'd8);
    change_req = 1'b1;
    key(4'hF); key(4'd3);
    ticks(5); settle();
    checkv("t5_np_expire", 16'(status), 16'd0);

    // 6: async reset mid-entry in NEW_PIN
    try4(4'd5, 4'd6, 4'd7, 4'd8);
    key(4'hF); key(4'd1); key(4'd2); settle();
    checkv("t6_pre", 16'(entry_count), 16'd2);
    rst = 1'b1; key_valid = 1'b0; model_reset();
    #1;
    checkv("t6_rst_status", 16'(status), 16'd0);
    checkv("t6_rst_entry", entry, 16'h0000);
    checkv("t6_rst_count", 16'(entry_count), 16'd0);
    checkv("t6_rst_timer", 16'(timer), 16'd0);
    @(negedge clk); #1;
    rst = 1'b0; change_req = 1'b0; model_step();
    try4(4'd1, 4'd2, 4'd3, 4'd4); settle();
    checkv("t6_initpin", 16'(status), 16'd1);

    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
